// File: rtl/data_cache_controller.sv
// Miss sequencer for a 2-way write-back data cache: gates cache enables, stalls the CPU,
// sequences write-back and refill over a line-wide memory port, and counts hits and misses.
module data_cache_controller #(
    parameter int LINE_OFFSET_BITS = 5,
    parameter int MEM_TIMEOUT      = 64,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [31:0]          cpu_address,
    input  logic                 cache_hit,
    input  logic                 victim_dirty,
    input  logic [31:0]          victim_address,
    input  logic                 mem_ready,
    output logic                 cpu_stall,
    output logic                 cache_read_enable,
    output logic                 cache_write_enable,
    output logic                 cache_refill,
    output logic                 mem_read_req,
    output logic                 mem_write_req,
    output logic [31:0]          mem_address,
    output logic                 mem_error,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    localparam int               TMO_W     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(MEM_TIMEOUT - 1);
    localparam logic [31:0]      LINE_MASK = ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, UPDATE} state_t;

    state_t           state;
    logic [31:0]      line_address;
    logic [TMO_W-1:0] tmo_count;
    logic             retry_flag;
    logic             req;
    logic             in_idle;
    logic             tmo_hit;

    // Reset also masks the combinational outputs so everything reads 0 while it is held.
    assign req                = cpu_read | cpu_write;
    assign in_idle            = reset && (state == IDLE);
    assign cpu_stall          = reset && ((state != IDLE) || (req && !cache_hit));
    assign cache_read_enable  = in_idle && cpu_read && !cpu_write;
    assign cache_write_enable = in_idle && cpu_write && cache_hit;
    assign tmo_hit            = (tmo_count == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            line_address  <= '0;
            tmo_count     <= '0;
            retry_flag    <= 1'b0;
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
            mem_address   <= '0;
            cache_refill  <= 1'b0;
            mem_error     <= 1'b0;
            hit_count     <= '0;
            miss_count    <= '0;
        end else begin
            cache_refill <= 1'b0;
            mem_error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && cache_hit) begin
                        // The retry that follows a refill was already counted as a miss.
                        if (!retry_flag) hit_count <= hit_count + CNT_WIDTH'(1);
                        retry_flag <= 1'b0;
                    end else if (req) begin
                        miss_count   <= miss_count + CNT_WIDTH'(1);
                        line_address <= cpu_address & LINE_MASK;
                        tmo_count    <= '0;
                        if (victim_dirty) begin
                            state         <= WRITEBACK;
                            mem_write_req <= 1'b1;
                            mem_address   <= victim_address & LINE_MASK;
                        end else begin
                            state        <= REFILL;
                            mem_read_req <= 1'b1;
                            mem_address  <= cpu_address & LINE_MASK;
                        end
                    end
                end
                WRITEBACK, REFILL: begin
                    if (mem_ready) begin
                        tmo_count     <= '0;
                        mem_write_req <= 1'b0;
                        if (state == WRITEBACK) begin
                            state        <= REFILL;
                            mem_read_req <= 1'b1;
                            mem_address  <= line_address;
                        end else begin
                            state        <= UPDATE;
                            mem_read_req <= 1'b0;
                            mem_address  <= '0;
                            cache_refill <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        // Abandon the transfer; the held CPU access will miss again from IDLE.
                        state         <= IDLE;
                        mem_write_req <= 1'b0;
                        mem_read_req  <= 1'b0;
                        mem_address   <= '0;
                        mem_error     <= 1'b1;
                        retry_flag    <= 1'b0;
                        tmo_count     <= '0;
                    end else begin
                        tmo_count <= tmo_count + TMO_W'(1);
                    end
                end
                UPDATE: begin
                    retry_flag <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache_controller.sv
// Randomized bench for data_cache_controller: the bench plays DataCache and memory and
// predicts each access's transfer sequence, latency and counters from the access rules.
module tb_data_cache_controller;

    localparam int          MEM_TIMEOUT = 64;
    localparam logic [31:0] LMASK       = 32'hFFFF_FFE0;

    logic        clk;
    logic        reset;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_address;
    logic        cache_hit;
    logic        victim_dirty;
    logic [31:0] victim_address;
    logic        mem_ready;
    logic        cpu_stall;
    logic        cache_read_enable;
    logic        cache_write_enable;
    logic        cache_refill;
    logic        mem_read_req;
    logic        mem_write_req;
    logic [31:0] mem_address;
    logic        mem_error;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_hit = 0;
    int exp_miss = 0;

    data_cache_controller #(
        .LINE_OFFSET_BITS(5),
        .MEM_TIMEOUT     (MEM_TIMEOUT),
        .CNT_WIDTH       (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_read          (cpu_read),
        .cpu_write         (cpu_write),
        .cpu_address       (cpu_address),
        .cache_hit         (cache_hit),
        .victim_dirty      (victim_dirty),
        .victim_address    (victim_address),
        .mem_ready         (mem_ready),
        .cpu_stall         (cpu_stall),
        .cache_read_enable (cache_read_enable),
        .cache_write_enable(cache_write_enable),
        .cache_refill      (cache_refill),
        .mem_read_req      (mem_read_req),
        .mem_write_req     (mem_write_req),
        .mem_address       (mem_address),
        .mem_error         (mem_error),
        .hit_count         (hit_count),
        .miss_count        (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drop the request after the completing edge, then check idle outputs and counters.
    task automatic finish_access(input string tag);
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        #2;
        check_val({tag, "_idle_outs"},
                  {cpu_stall, cache_read_enable, cache_write_enable, mem_read_req, mem_write_req}, 0);
        check_val({tag, "_hit_count"}, hit_count, exp_hit);
        check_val({tag, "_miss_count"}, miss_count, exp_miss);
    endtask

    // One CPU access; wbw/rdw are the extra cycles memory waits before mem_ready.
    task automatic access(input string tag, input logic [31:0] a, input logic rd, input logic wr,
                          input logic hit, input logic dirty, input logic [31:0] va,
                          input int wbw, input int rdw);
        int stalled, wbn, rdn, refills, both, errs;
        logic [31:0] wba, rda;
        logic done;
        stalled = 0; wbn = 0; rdn = 0; refills = 0; both = 0; errs = 0;
        wba = '0; rda = '0; done = 1'b0;
        cpu_address    = a;
        cpu_read       = rd;
        cpu_write      = wr;
        cache_hit      = hit;
        victim_dirty   = dirty;
        victim_address = va;
        mem_ready      = 1'b0;
        if (hit) exp_hit++;
        else exp_miss++;
        #1;
        for (int c = 0; c < 300 && !done; c++) begin
            if (mem_write_req && mem_read_req) both++;
            if (mem_error) errs++;
            if (cache_refill) refills++;
            if (mem_write_req) begin
                wbn++;
                if (wbn == 1) wba = mem_address;
            end
            if (mem_read_req) begin
                rdn++;
                if (rdn == 1) rda = mem_address;
            end
            if (!cpu_stall) begin
                done = 1'b1;
                check_val({tag, "_rd_en"}, cache_read_enable, rd & ~wr);
                check_val({tag, "_wr_en"}, cache_write_enable, wr);
            end else begin
                stalled++;
                if (c == 0) check_val({tag, "_miss_wr_en"}, cache_write_enable, 0);
            end
            mem_ready = (mem_write_req && wbn == wbw + 1) || (mem_read_req && rdn == rdw + 1);
            if (cache_refill) cache_hit = 1'b1;
            if (!done) begin
                @(negedge clk);
                #2;
            end
        end
        check_val({tag, "_done"}, done, 1);
        if (hit) begin
            check_val({tag, "_stall_cycles"}, stalled, 0);
        end else begin
            check_val({tag, "_stall_cycles"}, stalled, 2 + (dirty ? wbw + 1 : 0) + rdw + 1);
            check_val({tag, "_wb_cycles"}, wbn, dirty ? wbw + 1 : 0);
            if (dirty) check_val({tag, "_wb_addr"}, wba, va & LMASK);
            check_val({tag, "_rd_cycles"}, rdn, rdw + 1);
            check_val({tag, "_rd_addr"}, rda, a & LMASK);
            check_val({tag, "_refills"}, refills, 1);
            check_val({tag, "_both_req"}, both, 0);
            check_val({tag, "_errors"}, errs, 0);
        end
        finish_access(tag);
    endtask

    initial begin
        int rdn, errs, r;
        logic [31:0] a;
        reset = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0;
        cache_hit = 1'b0; victim_dirty = 1'b0; victim_address = '0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check_val("rst_outs", {cpu_stall, cache_read_enable, cache_write_enable, cache_refill,
                               mem_read_req, mem_write_req, mem_error}, 0);
        check_val("rst_counts", {hit_count, miss_count}, 0);
        reset = 1'b1;

        // Reset while a refill is outstanding
        @(negedge clk);
        #2;
        cpu_address = 32'h0000_1240;
        cpu_read    = 1'b1;
        @(negedge clk);
        #2;
        check_val("rst_pre_rd_req", mem_read_req, 1);
        check_val("rst_pre_miss", miss_count, 1);
        reset = 1'b0;
        #1;
        check_val("rst_mid_outs", {cpu_stall, cache_read_enable, cache_write_enable, cache_refill,
                                   mem_read_req, mem_write_req, mem_error}, 0);
        check_val("rst_mid_addr", mem_address, 0);
        check_val("rst_mid_counts", {hit_count, miss_count}, 0);
        @(negedge clk);
        #2;
        check_val("rst_next_rd_req", mem_read_req, 0);
        cpu_read = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        #2;

        access("hit_read", 32'h0000_0AA0, 1, 0, 1, 0, 32'h0, 0, 0);
        access("clean_miss", 32'h0000_2AA0, 1, 0, 0, 0, 32'h0, 0, 3);
        access("dirty_miss", 32'h0000_4AA0, 0, 1, 0, 1, 32'h0000_0AA0, 1, 2);
        access("rw_hit", 32'h0000_0AA0, 1, 1, 1, 0, 32'h0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(1, 3);
            access($sformatf("rnd%0d", i), $urandom, r[0], r[1], $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Memory never answers: expect a timeout, then the same access misses again
        a = 32'h2000_0047;
        cpu_address = a; cpu_read = 1'b1; cpu_write = 1'b0;
        cache_hit = 1'b0; victim_dirty = 1'b0; mem_ready = 1'b0;
        exp_miss++;
        rdn = 0; errs = 0;
        for (int c = 0; c < MEM_TIMEOUT + 10 && errs == 0; c++) begin
            @(negedge clk);
            #2;
            if (mem_error) errs = 1;
            else if (mem_read_req) rdn++;
        end
        check_val("tmo_error", errs, 1);
        check_val("tmo_wait_cycles", rdn, MEM_TIMEOUT);
        check_val("tmo_stall", cpu_stall, 1);
        check_val("tmo_req_dropped", mem_read_req, 0);
        exp_miss++;
        @(negedge clk);
        #2;
        check_val("tmo_reissue", mem_read_req, 1);
        check_val("tmo_reissue_addr", mem_address, a & LMASK);
        check_val("tmo_err_pulse", mem_error, 0);
        mem_ready = 1'b1;
        @(negedge clk);
        #2;
        mem_ready = 1'b0;
        check_val("tmo_refill", cache_refill, 1);
        cache_hit = 1'b1;
        @(negedge clk);
        #2;
        check_val("tmo_retry_stall", cpu_stall, 0);
        check_val("tmo_retry_rd_en", cache_read_enable, 1);
        finish_access("tmo");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
